// File: rtl/core_pkg.sv
// Shared core types for the execute stage: engine encoding, result-arbiter
// state encoding and the default watchdog limit.
package core_pkg;

  typedef enum logic [2:0] {
    ENG_ALU = 3'd0,
    ENG_MUL = 3'd1,
    ENG_DIV = 3'd2,
    ENG_LSU = 3'd3
  } exec_engine_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_HOLD = 2'd2
  } exec_arb_state_e;

  localparam int EXEC_ARB_TIMEOUT_DEF = 64;

  // Engine enum to arbiter port index; unknown encodings land out of range.
  function automatic int exec_engine_idx(input exec_engine_e eng);
    int idx;
    case (eng)
      ENG_ALU: idx = 0;
      ENG_MUL: idx = 1;
      ENG_DIV: idx = 2;
      ENG_LSU: idx = 3;
      default: idx = 7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/core_exec_arb_wdog.sv
// Watchdog for the result arbiter WAIT state: counts WAIT cycles from zero and
// flags expiry on the cycle the count reaches TIMEOUT-1.
module core_exec_arb_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count while waiting; held at zero otherwise so entry always starts fresh.
  always_comb begin
    cnt_d = {CNT_W{1'b0}};
    if (active) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = active && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/core_exec_result_arb.sv
// Execute-stage result arbiter: one operation in flight, captures the selected
// engine's result into a registered writeback slot. Optional watchdog under
// CORE_EXEC_ARB_WDOG_EN.
module core_exec_result_arb
  import core_pkg::*;
#(
  parameter int N_ENG   = 4,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = EXEC_ARB_TIMEOUT_DEF,
  parameter int ENG_W   = $clog2(N_ENG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ENG_W-1:0]      issue_engine,
  input  logic [4:0]            issue_rd,
  input  logic [N_ENG-1:0]      eng_valid,
  output logic [N_ENG-1:0]      eng_ready,
  input  logic [N_ENG*XLEN-1:0] eng_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [XLEN-1:0]       wb_result,
  output logic [4:0]            wb_rd,
  output logic [ENG_W-1:0]      wb_engine,
  output logic                  wb_err,
  output logic                  busy
);

  exec_arb_state_e   state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_result_q, wb_result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [ENG_W-1:0]  wb_engine_q, wb_engine_d;
  logic              wb_err_q, wb_err_d;

  logic              sel_valid_s;
  logic [XLEN-1:0]   sel_result_s;
  logic              issue_ready_s;
  logic              issue_fire_s;
  logic              issue_legal_s;
  logic              wdog_expired_s;
  logic [N_ENG-1:0]  eng_ready_s;

`ifdef CORE_EXEC_ARB_WDOG_EN
  core_exec_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state_q == ARB_WAIT),
    .expired (wdog_expired_s)
  );
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 1);
  assign wdog_expired_s   = 1'b0;
`endif

  // Mux the latched engine's handshake and result; ready is state/flush only.
  always_comb begin
    sel_valid_s  = 1'b0;
    sel_result_s = {XLEN{1'b0}};
    eng_ready_s  = {N_ENG{1'b0}};
    for (int i = 0; i < N_ENG; i++) begin
      sel_valid_s    = sel_valid_s | ((wb_engine_q == ENG_W'(i)) & eng_valid[i]);
      sel_result_s   = sel_result_s |
                       ({XLEN{wb_engine_q == ENG_W'(i)}} & eng_result[i*XLEN +: XLEN]);
      eng_ready_s[i] = (state_q == ARB_WAIT) & ~flush & (wb_engine_q == ENG_W'(i));
    end
  end

  assign issue_ready_s = ~flush & ((state_q == ARB_IDLE) | ((state_q == ARB_HOLD) & wb_ready));
  assign issue_fire_s  = issue_valid & issue_ready_s;
  assign issue_legal_s = ({1'b0, issue_engine} < (ENG_W+1)'(N_ENG));

  // Next state and writeback payload; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_engine_d = wb_engine_q;
    wb_err_d    = wb_err_q;
    if (flush) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE, ARB_HOLD: begin
          if (issue_fire_s) begin
            wb_rd_d     = issue_rd;
            wb_engine_d = issue_engine;
            if (issue_legal_s) begin
              state_d = ARB_WAIT;
            end else begin
              state_d     = ARB_HOLD;
              wb_err_d    = 1'b1;
              wb_result_d = {XLEN{1'b0}};
            end
          end else if ((state_q == ARB_HOLD) && wb_ready) begin
            state_d = ARB_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        ARB_WAIT: begin
          // A result arriving on the expiry cycle still wins.
          if (sel_valid_s) begin
            state_d     = ARB_HOLD;
            wb_result_d = sel_result_s;
            wb_err_d    = 1'b0;
          end else if (wdog_expired_s) begin
            state_d     = ARB_HOLD;
            wb_result_d = {XLEN{1'b0}};
            wb_err_d    = 1'b1;
          end else begin
            state_d = ARB_WAIT;
          end
        end
        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end
    wb_valid_d = (state_d == ARB_HOLD);
  end

  // State and writeback slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      wb_valid_q  <= 1'b0;
      wb_result_q <= {XLEN{1'b0}};
      wb_rd_q     <= 5'd0;
      wb_engine_q <= {ENG_W{1'b0}};
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_engine_q <= wb_engine_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign issue_ready = issue_ready_s;
  assign eng_ready   = eng_ready_s;
  assign wb_valid    = wb_valid_q;
  assign wb_result   = wb_result_q;
  assign wb_rd       = wb_rd_q;
  assign wb_engine   = wb_engine_q;
  assign wb_err      = wb_err_q;
  assign busy        = (state_q != ARB_IDLE);

endmodule
